// File: rtl/prf_wb_arbiter.sv
// Writeback arbiter: one holding buffer per write requestor, per-bank round-robin
// grant, registered per-bank writeback bus into the PRF / wakeup / ROB completion.
module prf_wb_arbiter #(
  parameter int PRF_WR_COUNT       = 7,
  parameter int PRF_BANK_COUNT     = 4,
  parameter int LOG_PRF_BANK_COUNT = 2,
  parameter int LOG_PR_COUNT       = 7,
  parameter int LOG_ROB_ENTRIES    = 7
) (
  input  logic                                                          CLK,
  input  logic                                                          nRST,
  input  logic [PRF_WR_COUNT-1:0]                                       WB_valid_by_wr,
  input  logic [PRF_WR_COUNT-1:0][31:0]                                 WB_data_by_wr,
  input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]                     WB_PR_by_wr,
  input  logic [PRF_WR_COUNT-1:0][LOG_ROB_ENTRIES-1:0]                  WB_ROB_index_by_wr,
  output logic [PRF_WR_COUNT-1:0]                                       WB_ready_by_wr,
  output logic [PRF_BANK_COUNT-1:0]                                     WB_bus_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][31:0]                               WB_bus_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_ROB_ENTRIES-1:0]                WB_bus_ROB_index_by_bank
);

  localparam int LOG_WR  = (PRF_WR_COUNT > 1) ? $clog2(PRF_WR_COUNT) : 1;
  localparam int UPPER_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  logic [PRF_WR_COUNT-1:0]                         buf_valid;
  logic [PRF_WR_COUNT-1:0][31:0]                   buf_data;
  logic [PRF_WR_COUNT-1:0][LOG_PRF_BANK_COUNT-1:0] buf_bank;
  logic [PRF_WR_COUNT-1:0][UPPER_W-1:0]            buf_upper_pr;
  logic [PRF_WR_COUNT-1:0][LOG_ROB_ENTRIES-1:0]    buf_rob_index;

  logic [PRF_BANK_COUNT-1:0][LOG_WR-1:0]           ptr;

  logic [PRF_WR_COUNT-1:0]                         grant_by_wr;
  logic [PRF_BANK_COUNT-1:0]                       grant_by_bank;
  logic [PRF_BANK_COUNT-1:0][LOG_WR-1:0]           grant_wr_by_bank;
  logic [PRF_WR_COUNT-1:0]                         accept_by_wr;

  // Grants look only at buffered state, so ready never depends on WB_valid.
  always_comb begin : arbitrate
    int   idx;
    logic found;
    grant_by_wr      = '0;
    grant_by_bank    = '0;
    grant_wr_by_bank = '0;
    idx              = 0;
    found            = 1'b0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      found = 1'b0;
      for (int k = 0; k < PRF_WR_COUNT; k++) begin
        idx = int'(ptr[b]) + k;
        if (idx >= PRF_WR_COUNT) idx = idx - PRF_WR_COUNT;
        if (!found && buf_valid[idx] && (buf_bank[idx] == LOG_PRF_BANK_COUNT'(b))) begin
          found               = 1'b1;
          grant_by_bank[b]    = 1'b1;
          grant_wr_by_bank[b] = LOG_WR'(idx);
          grant_by_wr[idx]    = 1'b1;
        end
      end
    end
  end

  assign WB_ready_by_wr = ~buf_valid | grant_by_wr;
  assign accept_by_wr   = WB_valid_by_wr & WB_ready_by_wr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      buf_valid     <= '0;
      buf_data      <= '0;
      buf_bank      <= '0;
      buf_upper_pr  <= '0;
      buf_rob_index <= '0;
    end else begin
      for (int r = 0; r < PRF_WR_COUNT; r++) begin
        if (accept_by_wr[r]) begin
          buf_valid[r]     <= 1'b1;
          buf_data[r]      <= WB_data_by_wr[r];
          buf_bank[r]      <= WB_PR_by_wr[r][LOG_PRF_BANK_COUNT-1:0];
          buf_upper_pr[r]  <= WB_PR_by_wr[r][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
          buf_rob_index[r] <= WB_ROB_index_by_wr[r];
        end else if (grant_by_wr[r]) begin
          buf_valid[r] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (grant_by_bank[b]) begin
          ptr[b] <= (grant_wr_by_bank[b] == LOG_WR'(PRF_WR_COUNT - 1)) ? '0
                                                                       : grant_wr_by_bank[b] + 1'b1;
        end
      end
    end
  end

  // Idle banks drop valid but keep their last payload.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      WB_bus_valid_by_bank     <= '0;
      WB_bus_data_by_bank      <= '0;
      WB_bus_upper_PR_by_bank  <= '0;
      WB_bus_ROB_index_by_bank <= '0;
    end else begin
      WB_bus_valid_by_bank <= grant_by_bank;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (grant_by_bank[b]) begin
          WB_bus_data_by_bank[b]      <= buf_data[grant_wr_by_bank[b]];
          WB_bus_upper_PR_by_bank[b]  <= buf_upper_pr[grant_wr_by_bank[b]];
          WB_bus_ROB_index_by_bank[b] <= buf_rob_index[grant_wr_by_bank[b]];
        end
      end
    end
  end

endmodule
